plru_tree: RTL

Multi-set tree pseudo-LRU replacement engine for the set-associative caches. It generalises the 2/4-way single-set generator to any power-of-two associativity and many sets. Each set holds its own (SET_ASSOC-1)-bit tree. The block adds an init sweep FSM and invalid-way preference. It sits beside the tag array and is queried on miss, then updated on every hit or refill.

---
 rtl/plru_pkg.sv | 19 +
 rtl/plru_tree_if.sv | 27 ++
 rtl/plru_tree_update.sv | 39 +++
 rtl/plru_tree.sv | 124 ++++++++++++
 4 files changed

// File: rtl/plru_pkg.sv
// Shared types and default geometry for the multi-set tree pseudo-LRU engine.
// Blocks take SET_ASSOC/SET_NUM as parameters and default them from here.
package plru_pkg;

  localparam int PLRU_SET_ASSOC = 4;
  localparam int PLRU_SET_NUM   = 64;
  localparam int PLRU_NODES     = PLRU_SET_ASSOC - 1;
  localparam int PLRU_WAY_W     = $clog2(PLRU_SET_ASSOC);
  localparam int PLRU_SET_W     = $clog2(PLRU_SET_NUM);

  // Tree bits for the default geometry; node 0 is the root, heap ordered.
  typedef logic [PLRU_NODES-1:0] plru_tree_t;

  typedef enum logic {
    SWEEP = 1'b0,
    READY = 1'b1
  } plru_init_state_e;

endpackage

// File: rtl/plru_tree_if.sv
// Update/query bus between the tag-array controller (master) and plru_tree (slave).
interface plru_tree_if import plru_pkg::*; #(
  parameter int SET_ASSOC = PLRU_SET_ASSOC,
  parameter int SET_NUM   = PLRU_SET_NUM
);
  localparam int SET_W = $clog2(SET_NUM);
  localparam int WAY_W = $clog2(SET_ASSOC);

  logic                 init_done;
  logic [SET_W-1:0]     upd_set;
  logic [SET_ASSOC-1:0] upd_access;
  logic                 update;
  logic [SET_W-1:0]     qry_set;
  logic [SET_ASSOC-1:0] qry_valid;
  logic [WAY_W-1:0]     repl_index;

  modport master (
    output upd_set, upd_access, update, qry_set, qry_valid,
    input  init_done, repl_index
  );

  modport slave (
    input  upd_set, upd_access, update, qry_set, qry_valid,
    output init_done, repl_index
  );

endinterface

// File: rtl/plru_tree_update.sv
// Combinational tree update: point every node on the accessed way's path away from it.
// Multi-hot access resolves to the highest set bit; all-zero passes the tree through.
module plru_tree_update import plru_pkg::*; #(
  parameter int SET_ASSOC = PLRU_SET_ASSOC
) (
  input  logic [SET_ASSOC-2:0] tree_i,
  input  logic [SET_ASSOC-1:0] way_i,
  output logic [SET_ASSOC-2:0] tree_o
);
  localparam int LVL = $clog2(SET_ASSOC);

  logic [LVL-1:0] way_idx;
  logic           way_hit;
  logic [LVL-1:0] node;

  always_comb begin
    way_idx = '0;
    way_hit = 1'b0;
    for (int i = 0; i < SET_ASSOC; i++) begin
      if (way_i[i]) begin
        way_idx = LVL'(i);
        way_hit = 1'b1;
      end
    end
  end

  // Level l node on the path is (2^l - 1) + top l bits of the way index.
  always_comb begin
    tree_o = tree_i;
    node   = '0;
    if (way_hit) begin
      for (int l = 0; l < LVL; l++) begin
        node         = LVL'((1 << l) - 1) + LVL'(way_idx >> (LVL - l));
        tree_o[node] = ~way_idx[LVL-1-l];
      end
    end
  end

endmodule

// File: rtl/plru_tree.sv
// Multi-set tree pseudo-LRU with init sweep and invalid-way preference.
// PLRU_FWD_EN: same-set query sees the post-update tree in the update cycle.
module plru_tree import plru_pkg::*; #(
  parameter int SET_ASSOC  = PLRU_SET_ASSOC,
  parameter int SET_NUM    = PLRU_SET_NUM,
  parameter int INIT_SWEEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  plru_tree_if.slave  bus
);
  localparam int NODES = SET_ASSOC - 1;
  localparam int SET_W = $clog2(SET_NUM);
  localparam int WAY_W = $clog2(SET_ASSOC);

  plru_init_state_e state_q, state_d;
  logic [SET_W-1:0] cnt_q, cnt_d;
  logic             sweep_we;
  logic             upd_we;
  logic             init_done;

  logic [NODES-1:0] tree_q [SET_NUM];
  logic [NODES-1:0] upd_tree;
  logic [NODES-1:0] qry_tree;

  assign init_done     = (state_q == READY);
  assign bus.init_done = init_done;
  assign upd_we        = bus.update & init_done & (|bus.upd_access);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_we = 1'b0;
    case (state_q)
      SWEEP: begin
        sweep_we = 1'b1;
        cnt_d    = cnt_q + SET_W'(1);
        if (cnt_q == SET_W'(SET_NUM - 1)) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = SWEEP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (INIT_SWEEP != 0) ? SWEEP : READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  plru_tree_update #(.SET_ASSOC(SET_ASSOC)) u_upd_wr (
    .tree_i (tree_q[bus.upd_set]),
    .way_i  (bus.upd_access),
    .tree_o (upd_tree)
  );

  // Sweep and update are exclusive: updates only commit once READY.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (INIT_SWEEP == 0) begin
        for (int s = 0; s < SET_NUM; s++) begin
          tree_q[s] <= '0;
        end
      end
    end else if (sweep_we) begin
      tree_q[cnt_q] <= '0;
    end else if (upd_we) begin
      tree_q[bus.upd_set] <= upd_tree;
    end
  end

`ifdef PLRU_FWD_EN
  logic [NODES-1:0] fwd_tree;

  plru_tree_update #(.SET_ASSOC(SET_ASSOC)) u_upd_fwd (
    .tree_i (tree_q[bus.qry_set]),
    .way_i  (bus.upd_access),
    .tree_o (fwd_tree)
  );

  assign qry_tree = (upd_we && (bus.upd_set == bus.qry_set)) ? fwd_tree : tree_q[bus.qry_set];
`else
  assign qry_tree = tree_q[bus.qry_set];
`endif

  logic [WAY_W-1:0] tree_victim;
  logic [WAY_W-1:0] walk_node;
  logic [WAY_W-1:0] inv_idx;
  logic             inv_any;

  // The bits collected along the walk form the leaf's way index, MSB first.
  always_comb begin
    tree_victim = '0;
    walk_node   = '0;
    for (int l = 0; l < WAY_W; l++) begin
      walk_node   = WAY_W'((1 << l) - 1) + tree_victim;
      tree_victim = (tree_victim << 1) | WAY_W'(qry_tree[walk_node]);
    end
  end

  always_comb begin
    inv_idx = '0;
    inv_any = 1'b0;
    for (int i = SET_ASSOC - 1; i >= 0; i--) begin
      if (!bus.qry_valid[i]) begin
        inv_idx = WAY_W'(i);
        inv_any = 1'b1;
      end
    end
  end

  assign bus.repl_index = inv_any ? inv_idx : tree_victim;

endmodule
